// File: rtl/sg90_ramp.sv
// Slew-rate limiter for the SG90 servo: walks sg90_duty toward an accepted
// target by one step per servo frame, then holds for a settle period.
module sg90_ramp #(
  parameter int CLK_FRE     = 50,
  parameter int STEP_US     = 20000,
  parameter int INIT_DUTY   = 50,
  parameter int HOLD_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target_duty,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [7:0] sg90_duty,
  output logic       busy,
  output logic       frame_tick
);

  localparam int FRAME_CYC = CLK_FRE * STEP_US;
  localparam int CW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    tgt;
  logic [HW-1:0] hold;
  logic          accept;

  assign accept  = target_valid && target_ready;
  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

  // Tick is registered from the next count so it is high exactly while cnt == LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      frame_tick <= (cnt_nxt == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MOVE;
      MOVE:    if (frame_tick && sg90_duty == tgt) state_nxt = SETTLE;
      SETTLE: begin
        if (hold == '0) state_nxt = IDLE;
        else if (frame_tick && hold == HW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    target_ready = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE:    target_ready = 1'b1;
      MOVE:    busy = 1'b1;
      SETTLE:  busy = 1'b1;
      default: target_ready = 1'b0;
    endcase
  end

  // Steps only move toward a clamped target, so duty stays within 0..100.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sg90_duty <= 8'(INIT_DUTY);
      tgt       <= 8'(INIT_DUTY);
      hold      <= '0;
    end else begin
      if (accept)
        tgt <= (target_duty > 8'd100) ? 8'd100 : target_duty;
      if (state == MOVE && frame_tick) begin
        if (sg90_duty < tgt)      sg90_duty <= sg90_duty + 8'd1;
        else if (sg90_duty > tgt) sg90_duty <= sg90_duty - 8'd1;
        else                      hold      <= HW'(HOLD_FRAMES);
      end
      if (state == SETTLE && frame_tick && hold != '0)
        hold <= hold - 1'b1;
    end
  end

endmodule

// File: tb/tb_sg90_ramp.sv
// Directed bench for sg90_ramp: a HOLD_FRAMES=2 instance and a HOLD_FRAMES=0
// instance share clock and reset, both with a 10-cycle frame.
module tb_sg90_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] target_duty, t0_target_duty;
  logic       target_valid, t0_target_valid;
  logic       target_ready, t0_target_ready;
  logic [7:0] sg90_duty, t0_sg90_duty;
  logic       busy, t0_busy;
  logic       frame_tick, t0_frame_tick;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sg90_ramp #(.CLK_FRE(1), .STEP_US(10), .INIT_DUTY(50), .HOLD_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .target_duty(target_duty), .target_valid(target_valid),
    .target_ready(target_ready), .sg90_duty(sg90_duty),
    .busy(busy), .frame_tick(frame_tick)
  );

  sg90_ramp #(.CLK_FRE(1), .STEP_US(10), .INIT_DUTY(50), .HOLD_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst),
    .target_duty(t0_target_duty), .target_valid(t0_target_valid),
    .target_ready(t0_target_ready), .sg90_duty(t0_sg90_duty),
    .busy(t0_busy), .frame_tick(t0_frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  // One clock, sampling 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for frame_tick on the chosen instance, then crosses the edge that uses it.
  task automatic tick(input bit zero_hold, input string tag);
    int n = 0;
    while ((zero_hold ? t0_frame_tick : frame_tick) !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) timeout(tag);
    step();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (target_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) timeout(tag);
  endtask

  task automatic send(input logic [7:0] val);
    target_duty  = val;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    target_duty = 8'd0;      target_valid = 1'b0;
    t0_target_duty = 8'd0;   t0_target_valid = 1'b0;
    step(); step();
    check("rst_duty", sg90_duty, 50);
    check("rst_ready", target_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tick", frame_tick, 0);
    rst = 1'b0;

    // Frame cadence: first tick 9 edges after release, one cycle wide.
    repeat (8) step();
    check("tick_c8", frame_tick, 0);
    step();
    check("tick_c9", frame_tick, 1);
    step();
    check("tick_c10", frame_tick, 0);

    // Ramp up to 53.
    send(8'd53);
    check("up_ready", target_ready, 0);
    check("up_busy", busy, 1);
    check("up_duty0", sg90_duty, 50);
    tick(0, "up_t1"); check("up_duty1", sg90_duty, 51);
    tick(0, "up_t2"); check("up_duty2", sg90_duty, 52);
    tick(0, "up_t3"); check("up_duty3", sg90_duty, 53);
    tick(0, "up_t4"); check("up_settle_duty", sg90_duty, 53);
    check("up_settle_busy", busy, 1);
    tick(0, "up_t5"); check("up_t5_ready", target_ready, 0);
    tick(0, "up_t6"); check("up_t6_ready", target_ready, 1);
    check("up_t6_busy", busy, 0);

    // Walk to 98, then clamp 200 to 100.
    send(8'd98);
    wait_ready("to98");
    check("at98", sg90_duty, 98);
    send(8'd200);
    tick(0, "cl_t1"); check("cl_duty1", sg90_duty, 99);
    tick(0, "cl_t2"); check("cl_duty2", sg90_duty, 100);
    tick(0, "cl_t3"); check("cl_duty3", sg90_duty, 100);
    wait_ready("cl_done");
    check("cl_final", sg90_duty, 100);

    send(8'd97);
    tick(0, "dn_t1"); check("dn_duty1", sg90_duty, 99);
    tick(0, "dn_t2"); check("dn_duty2", sg90_duty, 98);
    tick(0, "dn_t3"); check("dn_duty3", sg90_duty, 97);
    wait_ready("dn_done");

    // Request pulsed while busy is dropped; a held request lands on first ready.
    send(8'd95);
    send(8'd10);
    check("ign_ready", target_ready, 0);
    tick(0, "ign_t1"); check("ign_duty1", sg90_duty, 96);
    tick(0, "ign_t2"); check("ign_duty2", sg90_duty, 95);
    tick(0, "ign_t3"); check("ign_duty3", sg90_duty, 95);
    target_duty = 8'd50;
    target_valid = 1'b1;
    begin
      int n = 0;
      while (target_ready !== 1'b1 && n < 100) begin
        step();
        n++;
      end
      if (n >= 100) timeout("hold_valid");
    end
    step();
    target_valid = 1'b0;
    check("held_busy", busy, 1);
    tick(0, "held_t1"); check("held_duty1", sg90_duty, 94);
    wait_ready("held_done");
    check("held_final", sg90_duty, 50);

    // Target equal to current duty.
    send(8'd50);
    check("noop_busy0", busy, 1);
    tick(0, "noop_t1"); check("noop_duty", sg90_duty, 50);
    check("noop_busy1", busy, 1);
    tick(0, "noop_t2"); check("noop_busy2", busy, 1);
    tick(0, "noop_t3"); check("noop_busy3", busy, 0);
    check("noop_final", sg90_duty, 50);

    // Zero hold instance.
    t0_target_duty = 8'd51;
    t0_target_valid = 1'b1;
    step();
    t0_target_valid = 1'b0;
    tick(1, "z_t1"); check("z_duty1", t0_sg90_duty, 51);
    tick(1, "z_t2"); check("z_settle_ready", t0_target_ready, 0);
    check("z_settle_busy", t0_busy, 1);
    step();
    check("z_idle_ready", t0_target_ready, 1);
    check("z_idle_busy", t0_busy, 0);

    // Reset during MOVE.
    send(8'd60);
    tick(0, "rm_t1"); check("rm_duty", sg90_duty, 51);
    #2 rst = 1'b1;
    #1;
    check("rm_duty_rst", sg90_duty, 50);
    check("rm_ready_rst", target_ready, 1);
    check("rm_busy_rst", busy, 0);
    step();
    rst = 1'b0;
    repeat (12) step();
    check("rm_still50", sg90_duty, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sg90_ramp.md
# sg90_ramp

Slew-rate limiter between the servo command source and the SG90 PWM generator. Accepts a target duty (0–100 % of the servo angle range) over a valid/ready handshake. Moves `sg90_duty` toward the target by one step per servo frame, so the horn never jumps. Holds the final position for a settle period before accepting the next command. Its `sg90_duty` output drives the PWM generator's `sg90_duty` input directly.

## Interface

Parameters:
- `CLK_FRE`, 50: clock frequency in MHz.
- `STEP_US`, 20000: step period in µs, one servo frame. Frame length is `FRAME_CYC = CLK_FRE*STEP_US` cycles.
- `INIT_DUTY`, 50: `sg90_duty` value after reset (centre position). Must be ≤ 100.
- `HOLD_FRAMES`, 5: frames held in SETTLE after the target is reached.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `target_duty` in 8: requested duty, 0–100.
- `target_valid` in 1: `target_duty` is valid this cycle.
- `target_ready` out 1: block can accept a target this cycle.
- `sg90_duty` out 8: current commanded duty, registered.
- `busy` out 1: high in MOVE or SETTLE.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.

## Operation

Frame timer:
- Free-running counter 0..`FRAME_CYC`-1; wraps to 0.
- `frame_tick` = 1 when the counter equals `FRAME_CYC`-1.
- Never cleared by a handshake, so steps stay aligned to frame boundaries.

Accept:
- A target is accepted on any cycle with `target_valid && target_ready`.
- Accepted value is clamped: values > 100 store as 100. Stored in `tgt` (8 bit).

State machine:
- **IDLE**: `target_ready`=1, `busy`=0. On accept → MOVE.
- **MOVE**: `target_ready`=0, `busy`=1. On `frame_tick`:
  - `sg90_duty` < `tgt`: increment by 1.
  - `sg90_duty` > `tgt`: decrement by 1.
  - `sg90_duty` == `tgt`: load hold counter with `HOLD_FRAMES`, go to SETTLE. No duty change that tick.
- **SETTLE**: `target_ready`=0, `busy`=1.
  - Hold counter = 0: go to IDLE on the next clock, regardless of tick.
  - Otherwise: decrement on each `frame_tick`; go to IDLE on the tick that brings it to 0.

Arithmetic:
- Duty and target are 8-bit unsigned.
- Never exceeds 100 and never underflows below 0, because clamping guarantees `tgt` ≤ 100 and steps only move toward `tgt`.
- Hold counter width is `$clog2(HOLD_FRAMES+1)`, minimum 1.

Boundary conditions:
- Accepting a target equal to the current duty enters MOVE, then SETTLE on the next tick with no duty change.
- `target_valid` while not ready is ignored. There is no queuing; the source must hold valid until ready.
- Reset mid-move returns at once to IDLE with `sg90_duty`=`INIT_DUTY`. Any pending target is lost.

## Timing

Reset values:
- `sg90_duty`=`INIT_DUTY`, `target_ready`=1, `busy`=0, `frame_tick`=0.
- Frame counter = 0, state = IDLE, `tgt`=`INIT_DUTY`.

Latency:
- Accept at clock edge N → state MOVE and `target_ready`=0, `busy`=1 visible after edge N.
- The first step happens on the first `frame_tick` after edge N. If the tick coincides with the accept cycle, it is not used for a step.
- `sg90_duty` changes on the clock edge that samples `frame_tick`=1 and is visible the cycle after the tick.
- Full move of D steps finishes D ticks after accept. Reaching SETTLE takes one more tick. IDLE follows `HOLD_FRAMES` further ticks (or 1 cycle when `HOLD_FRAMES`=0).

Output behaviour:
- `sg90_duty` changes at most once per frame, by exactly ±1.
- All outputs are registered, with no combinational path from inputs.

## Test plan

Use `CLK_FRE`=1, `STEP_US`=10 (`FRAME_CYC`=10), `HOLD_FRAMES`=2 unless stated.

1. **Reset values.** Assert `rst` mid-frame → `sg90_duty`=50, `target_ready`=1, `busy`=0 immediately. After release, `frame_tick` pulses every 10 cycles, the first one at cycle 9.
2. **Ramp up.** Target 53 accepted → duty 51, 52, 53 on three successive ticks. SETTLE on the 4th tick. `target_ready` returns to 1 on the 6th tick.
3. **Clamp and ramp down.** Target 200 from duty 98 → ends at 100, never 101. Then target 97 → 99, 98, 97.
4. **Ignored request.** `target_valid` pulsed with 10 while busy → ignored, ramp toward the original target continues unchanged. Holding valid until ready → accepted on the first ready cycle.
5. **No-op target.** Target = current duty (50) → duty stays 50. `busy`=1 for 3 ticks total (1 MOVE + 2 SETTLE).
6. **Zero hold.** `HOLD_FRAMES`=0, target 51 → 2 ticks after accept, SETTLE; `target_ready`=1 one cycle later. Separately, `rst` asserted during MOVE → duty 50, IDLE.
